// File: rtl/mem_init_pkg.sv
// Package: mem_init_pkg
// Shared types for the memory request initiator: FSM state encoding and
// response status codes returned to the client.
package mem_init_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_DENIED  = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

endpackage

// File: rtl/mem_prot_check.sv
// Module: mem_prot_check
// Combinational address-privilege check. A request is denied when it
// targets the protected window [PROT_LO, PROT_HI] without privilege.
// Ports:
//   addr_i    request address
//   priv_i    requester holds privilege for the protected window
//   denied_o  1 = request must not reach memory
module mem_prot_check #(
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] PROT_LO    = 8'hF0,
  parameter logic [ADDR_WIDTH-1:0] PROT_HI    = 8'hFF
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  priv_i,
  output logic                  denied_o
);

  // Range test as an offset from PROT_LO: the extra MSB is the borrow
  // (address below the window), the low bits are compared to the window
  // span. Avoids constant-true compares when the window touches the top.
  localparam logic [ADDR_WIDTH-1:0] SPAN = PROT_HI - PROT_LO;

  logic [ADDR_WIDTH:0] offset;
  logic                in_range;

  assign offset   = {1'b0, addr_i} - {1'b0, PROT_LO};
  assign in_range = !offset[ADDR_WIDTH] && (offset[ADDR_WIDTH-1:0] <= SPAN);
  assign denied_o = in_range && !priv_i;

endmodule

// File: rtl/mem_req_initiator.sv
// Module: mem_req_initiator
// Client-facing initiator for a start/ready memory responder. Accepts one
// request at a time (valid/ready), screens it with mem_prot_check, runs a
// single start/ready transaction for allowed requests (with a WAIT timeout),
// and returns a held response with status.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   req_valid/req_ready          request handshake (ready only in IDLE)
//   req_write/addr/wdata/priv    request fields
//   rsp_valid/rsp_ready          response handshake (valid held until ready)
//   rsp_rdata/rsp_status         read data (0 unless OK read), status code
//   mem_start                    one-cycle transaction strobe
//   mem_addr/mem_data_in         responder address / write data
//   mem_write_enable/read_enable responder enables, held through WAIT
//   mem_ready/mem_data_out       responder done / read data
//   denied_count                 saturating count of denied requests
module mem_req_initiator
  import mem_init_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 8,
  parameter logic [ADDR_WIDTH-1:0] PROT_LO        = 8'hF0,
  parameter logic [ADDR_WIDTH-1:0] PROT_HI        = 8'hFF,
  parameter int                    TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  req_priv,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_status,
  output logic                  mem_start,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_write_enable,
  output logic                  mem_read_enable,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic [7:0]            denied_count
);

  localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  state_e                state_q;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [1:0]            rsp_status_q;
  logic                  mem_start_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  mem_we_q;
  logic                  mem_re_q;
  logic [7:0]            denied_cnt_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic                  denied;

  mem_prot_check #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .PROT_LO    (PROT_LO),
    .PROT_HI    (PROT_HI)
  ) u_prot (
    .addr_i   (req_addr),
    .priv_i   (req_priv),
    .denied_o (denied)
  );

  assign cnt_d = cnt_q + CNT_W'(1);

  // The mem_* registers double as the request latches: they are loaded on
  // accept and held through WAIT, so no separate copy is kept. Privilege is
  // only needed at accept time and is not retained.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_status_q <= ST_OK;
      mem_start_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      denied_cnt_q <= '0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // req_ready rises one edge after reset release so it is 0 in reset
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            if (denied) begin
              state_q      <= RESP;
              rsp_valid_q  <= 1'b1;
              rsp_status_q <= ST_DENIED;
              rsp_rdata_q  <= '0;
              if (denied_cnt_q != 8'hFF) denied_cnt_q <= denied_cnt_q + 8'd1;
            end else begin
              state_q     <= ISSUE;
              mem_start_q <= 1'b1;
              mem_addr_q  <= req_addr;
              mem_wdata_q <= req_wdata;
              mem_we_q    <= req_write;
              mem_re_q    <= !req_write;
            end
          end
        end

        // mem_ready is not sampled here: a ready left high by the previous
        // operation must not complete this one.
        ISSUE: begin
          mem_start_q <= 1'b0;
          state_q     <= WAIT;
        end

        WAIT: begin
          cnt_q <= cnt_d;
          if (mem_ready || (cnt_d == CNT_MAX)) begin
            state_q      <= RESP;
            rsp_valid_q  <= 1'b1;
            rsp_status_q <= mem_ready ? ST_OK : ST_TIMEOUT;
            rsp_rdata_q  <= (mem_ready && !mem_we_q) ? mem_data_out : '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            cnt_q       <= '0;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready        = req_ready_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_rdata        = rsp_rdata_q;
  assign rsp_status       = rsp_status_q;
  assign mem_start        = mem_start_q;
  assign mem_addr         = mem_addr_q;
  assign mem_data_in      = mem_wdata_q;
  assign mem_write_enable = mem_we_q;
  assign mem_read_enable  = mem_re_q;
  assign denied_count     = denied_cnt_q;

endmodule
